// File: rtl/fifo_uart_drain.sv
// Drains a synchronous FIFO one byte at a time and sends each byte as 8N1 UART, LSB first.
// Every pop runs through IDLE -> POP -> CAPTURE so the FIFO's registered read data is
// sampled exactly one cycle after the pop strobe.
module fifo_uart_drain #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_r_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("fifo_uart_drain: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              baud_done;

  assign baud_done = (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      byte_count <= '0;
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
            state      <= POP;
          end
        end
        POP: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          shift <= fifo_r_data;
          tx    <= 1'b0;
          baud  <= '0;
          state <= START;
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // shift right so the next bit to send is always shift[1] -> shift[0]
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud       <= '0;
            byte_count <= byte_count + 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          baud  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Scoreboard bench for fifo_uart_drain: a queue-based FIFO model feeds the DUT, and a
// UART monitor decodes every frame and compares it with the bytes the stimulus queued.
module tb_fifo_uart_drain;
  localparam int CPB   = 4;
  localparam int CW    = 4;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [7:0]    fifo_r_data = '0;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic [CW-1:0] byte_count;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int rd_cycle = -100;
  int frame_end = -100;
  int model_count = 0;
  bit expect_b2b = 0;
  bit first_in_burst = 0;
  bit in_frame = 0;

  fifo_uart_drain #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected 10-bit frame, each bit held CPB samples: start 0, data LSB first, stop 1.
  function automatic logic [63:0] frame_wave(input logic [7:0] b);
    logic [63:0] w;
    int bi;
    w = '0;
    for (int k = 0; k < FRAME; k++) begin
      bi = k / CPB;
      if (bi == 0)      w[k] = 1'b0;
      else if (bi == 9) w[k] = 1'b1;
      else              w[k] = b[bi-1];
    end
    return w;
  endfunction

  // FIFO model: registered read data, empty flag refreshed on each clock edge.
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      chk("pop_only_when_nonempty", (fq.size() != 0), 1);
      if (fq.size() != 0) fifo_r_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Monitor: decodes frames from tx and checks them against the expected queue.
  initial begin
    logic        prev_tx;
    logic        rd_prev;
    logic [63:0] wave;
    logic [7:0]  want;
    bit          busy_ok;
    bit          pop_seen;
    bit          aborted;
    int          fall_cyc;
    prev_tx = 1'b1;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_tx = 1'b1;
        rd_prev = 1'b0;
        in_frame = 0;
      end else begin
        if (fifo_rd_en) begin
          rd_pulses++;
          rd_cycle = cyc;
          chk("rd_en_single_cycle", rd_prev, 0);
        end
        rd_prev = fifo_rd_en;
        if (prev_tx && !tx) begin
          in_frame = 1;
          fall_cyc = cyc;
          // IDLE decision cycle, POP and CAPTURE: tx falls two edges after rd_en rises.
          chk("pop_to_tx_fall_latency", fall_cyc - rd_cycle, 2);
          if (expect_b2b && !first_in_burst)
            chk("interframe_gap", fall_cyc - frame_end, 3);
          wave = '0;
          busy_ok = busy;
          pop_seen = 0;
          aborted = 0;
          for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (!rst_n) begin
              aborted = 1;
              break;
            end
            if (k < FRAME) begin
              wave[k] = tx;
              busy_ok = busy_ok && busy;
              pop_seen = pop_seen || fifo_rd_en;
            end
          end
          if (aborted) begin
            prev_tx = 1'b1;
            rd_prev = 1'b0;
          end else begin
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", 1, 0);
              want = 8'h00;
            end else begin
              want = exp_q.pop_front();
            end
            chk("frame_waveform", wave, frame_wave(want));
            chk("busy_during_frame", busy_ok, 1);
            chk("no_pop_during_frame", pop_seen, 0);
            model_count++;
            chk("byte_count_after_frame", byte_count, model_count % (1 << CW));
            chk("busy_low_after_stop", busy, 0);
            chk("tx_high_after_stop", tx, 1);
            frame_end = cyc;
            first_in_burst = 0;
            prev_tx = tx;
            rd_prev = fifo_rd_en;
          end
          in_frame = 0;
        end else begin
          prev_tx = tx;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fq.size() == 0 && !busy && !in_frame) begin
        done = 1;
        break;
      end
    end
    chk(name, done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_frame(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_frame) begin
        done = 1;
        break;
      end
    end
    chk(name, done, 1);
  endtask

  initial begin
    int lows, pops, busies, p0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_byte_count", byte_count, 0);
    rst_n = 1'b1;

    // Empty FIFO with drain enabled: nothing may happen.
    enable = 1'b1;
    lows = 0; pops = 0; busies = 0;
    repeat (200) begin
      @(negedge clk);
      if (!tx) lows++;
      if (fifo_rd_en) pops++;
      if (busy) busies++;
    end
    chk("empty_tx_low_cycles", lows, 0);
    chk("empty_pop_cycles", pops, 0);
    chk("empty_busy_cycles", busies, 0);
    chk("empty_byte_count", byte_count, 0);

    // Single byte.
    p0 = rd_pulses;
    push(8'hA5);
    wait_drain("single_drain_timeout", 200);
    chk("single_pop_count", rd_pulses - p0, 1);
    chk("single_byte_count", byte_count, 1);
    chk("single_fifo_empty", fifo_empty, 1);
    chk("single_busy_low", busy, 0);

    // Back-to-back burst.
    p0 = rd_pulses;
    expect_b2b = 1;
    first_in_burst = 1;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_drain("burst_drain_timeout", 400);
    expect_b2b = 0;
    chk("burst_pop_count", rd_pulses - p0, 3);
    chk("burst_byte_count", byte_count, 4);

    // Drop enable mid-frame: current frame finishes, no further pop.
    p0 = rd_pulses;
    push(8'($urandom));
    push(8'($urandom));
    wait_frame("enable_drop_frame_timeout", 100);
    repeat (3 * CPB) @(negedge clk);
    enable = 1'b0;
    repeat (FRAME + 30) @(negedge clk);
    chk("enable_drop_pop_count", rd_pulses - p0, 1);
    chk("enable_drop_byte_count", byte_count, 5);
    chk("enable_drop_fifo_left", fq.size(), 1);
    enable = 1'b1;
    wait_drain("enable_resume_timeout", 200);
    chk("enable_resume_pop_count", rd_pulses - p0, 2);
    chk("enable_resume_byte_count", byte_count, 6);

    // Reset in the middle of the data bits of 0x55.
    push(8'h55);
    push(8'hC3);
    wait_frame("reset_frame_timeout", 100);
    repeat (4 * CPB) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", tx, 1);
    chk("midframe_reset_busy", busy, 0);
    chk("midframe_reset_rd_en", fifo_rd_en, 0);
    chk("midframe_reset_byte_count", byte_count, 0);
    chk("midframe_reset_byte_was_popped", fq.size(), 1);
    void'(exp_q.pop_front());
    model_count = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain("after_reset_timeout", 200);
    chk("after_reset_byte_count", byte_count, 1);

    // Counter wrap: from zero, 17 random bytes with random spacing.
    @(negedge clk);
    rst_n = 1'b0;
    model_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    wait_drain("wrap_drain_timeout", 17 * (FRAME + 10));
    chk("wrap_byte_count", byte_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
